// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode constants, FSM state encoding and decode helper shared by
//            the pipelined ALU and its iterative multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] c_op_and  = 4'b0000;
    localparam logic [3:0] c_op_or   = 4'b0001;
    localparam logic [3:0] c_op_add  = 4'b0010;
    localparam logic [3:0] c_op_sltu = 4'b0011;
    localparam logic [3:0] c_op_xor  = 4'b0100;
    localparam logic [3:0] c_op_nor  = 4'b0101;
    localparam logic [3:0] c_op_sub  = 4'b0110;
    localparam logic [3:0] c_op_slt  = 4'b0111;
    localparam logic [3:0] c_op_sll  = 4'b1000;
    localparam logic [3:0] c_op_srl  = 4'b1001;
    localparam logic [3:0] c_op_sra  = 4'b1010;
    localparam logic [3:0] c_op_mul  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Opcodes 1100..1111 are reserved.
    function automatic logic is_illegal(input logic [3:0] op);
        return op[3] & op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_iter
// Brief    : Iterative shift-add multiplier, one multiplier bit per cycle;
//            returns the low DATA_WIDTH bits of the unsigned product.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product
);

    localparam int                c_cnt_w = $clog2(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);

    // The final partial sum is presented combinationally so the caller can
    // register it on the same edge that completes the last iteration.
    assign done    = r_busy && (r_cnt == c_last);
    assign product = w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_a    <= '0;
            r_b    <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_a    <= A;
            r_b    <= B;
        end else if (r_busy) begin
            r_acc <= w_acc_next;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Brief    : Valid/ready ALU with registered result and flags; single-cycle
//            ops complete in one cycle, MUL iterates for DATA_WIDTH cycles.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [3:0]            ALUop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero,
    output logic                  Illegal
);

    localparam int c_msb = DATA_WIDTH - 1;

    state_t                r_state;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_ovf;
    logic                  r_cout;
    logic                  r_zero;
    logic                  r_illegal;

    logic                  w_accept;
    logic                  w_mul_start;
    logic                  w_mul_done;
    logic [DATA_WIDTH-1:0] w_mul_product;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_add_ovf;
    logic                  w_sub_ovf;
    logic [SHAMT_W-1:0]    w_shamt;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_ovf;
    logic                  w_cout;
    logic                  w_ill;

    assign in_ready    = !rst && ((r_state == ST_IDLE) ||
                                  ((r_state == ST_DONE) && out_ready));
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (ALUop == c_op_mul);

    assign w_sum     = {1'b0, A} + {1'b0, B};
    assign w_diff    = {1'b0, A} + {1'b0, ~B} + {{DATA_WIDTH{1'b0}}, 1'b1};
    assign w_add_ovf = (A[c_msb] == B[c_msb]) && (w_sum[c_msb] != A[c_msb]);
    assign w_sub_ovf = (A[c_msb] != B[c_msb]) && (w_diff[c_msb] != A[c_msb]);
    assign w_shamt   = B[SHAMT_W-1:0];

    always_comb begin
        w_res  = '0;
        w_ovf  = 1'b0;
        w_cout = 1'b0;
        w_ill  = is_illegal(ALUop);
        case (ALUop)
            c_op_and:  w_res = A & B;
            c_op_or:   w_res = A | B;
            c_op_xor:  w_res = A ^ B;
            c_op_nor:  w_res = ~(A | B);
            c_op_add: begin
                w_res  = w_sum[c_msb:0];
                w_cout = w_sum[DATA_WIDTH];
                w_ovf  = w_add_ovf;
            end
            c_op_sub: begin
                w_res  = w_diff[c_msb:0];
                w_cout = w_diff[DATA_WIDTH];
                w_ovf  = w_sub_ovf;
            end
            c_op_slt:  w_res = {{(DATA_WIDTH-1){1'b0}}, w_diff[c_msb] ^ w_sub_ovf};
            c_op_sltu: w_res = {{(DATA_WIDTH-1){1'b0}}, ~w_diff[DATA_WIDTH]};
            c_op_sll:  w_res = A << w_shamt;
            c_op_srl:  w_res = A >> w_shamt;
            c_op_sra:  w_res = $unsigned($signed(A) >>> w_shamt);
            default:   w_res = '0;
        endcase
    end

    alu_mul_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .A       (A),
        .B       (B),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    // in_ready already restricts acceptance to IDLE or a draining DONE, so
    // acceptance is handled ahead of the per-state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_cout      <= 1'b0;
            r_zero      <= 1'b1;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            if (ALUop == c_op_mul) begin
                r_state     <= ST_BUSY;
                r_out_valid <= 1'b0;
            end else begin
                r_state     <= ST_DONE;
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_ovf       <= w_ovf;
                r_cout      <= w_cout;
                r_zero      <= (w_res == '0);
                r_illegal   <= w_ill;
            end
        end else begin
            case (r_state)
                ST_BUSY: begin
                    if (w_mul_done) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_mul_product;
                        r_ovf       <= 1'b0;
                        r_cout      <= 1'b0;
                        r_zero      <= (w_mul_product == '0);
                        r_illegal   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_IDLE: r_state <= ST_IDLE;
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign Result    = r_result;
    assign Overflow  = r_ovf;
    assign CarryOut  = r_cout;
    assign Zero      = r_zero;
    assign Illegal   = r_illegal;

endmodule
`default_nettype wire
